// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
// Holds the hex glyph table, the all-off code and the default slot length.
package seg7_scan_ctrl_pkg;

  localparam int unsigned PRESC_DIV_DEFAULT = 32'd50000;
  localparam logic [7:0]  SEG_BLANK         = 8'hFF;

  // Active-low gfedcba glyphs, index 15 (F) first down to index 0.
  localparam logic [15:0][6:0] HEX_SEG7 = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } disp_set_t;

  function automatic logic [6:0] hex_seg7(input logic [3:0] nib);
    return HEX_SEG7[nib];
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display-side bus of the scan controller: frame data in, scan index and
// segment drive out.
interface seg7_scan_if;

  logic        en;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        load;
  logic [1:0]  s;
  logic [7:0]  seg;
  logic        frame_done;

  modport master (
    output en, data, dp, blank, load,
    input  s, seg, frame_done
  );

  modport slave (
    input  en, data, dp, blank, load,
    output s, seg, frame_done
  );

endinterface

// File: rtl/seg7_scan_ctrl_hex_to_seg7.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module hex_to_seg7
  import seg7_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg7
);

  // Table lookup of the glyph for the selected nibble
  always_comb begin
    seg7 = hex_seg7(nib);
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with double-buffered frame data;
// new data is only promoted to the display at the digit-3 -> digit-0 wrap.
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int unsigned PRESC_DIV = PRESC_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  seg7_scan_if.slave bus
);

  localparam int unsigned      CNT_W    = (PRESC_DIV > 32'd1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESC_DIV - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       s_q, s_d;
  logic [7:0]       seg_q, seg_d;
  logic             frame_done_q, frame_done_d;
  logic             pend_valid_q, pend_valid_d;
  disp_set_t        pend_q, pend_d;
  disp_set_t        act_q, act_d;

  logic             tick_s;
  logic             wrap_s;
  logic [3:0]       nib_s;
  logic             dp_s;
  logic             blank_s;
  logic [6:0]       seg7_s;

  // Prescaler, scan index and the pending/active buffer hand-over
  always_comb begin
    tick_s       = bus.en && (cnt_q == CNT_LAST);
    wrap_s       = tick_s && (s_q == 2'd3);
    cnt_d        = cnt_q;
    s_d          = s_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    act_d        = act_q;
    frame_done_d = wrap_s;

    if (!bus.en) begin
      cnt_d = cnt_q;
    end else if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end

    if (tick_s) begin
      s_d = s_q + 2'd1;
    end else begin
      s_d = s_q;
    end

    // A load on the wrap edge lands in pending after the old pending is promoted.
    if (wrap_s && pend_valid_q) begin
      act_d        = pend_q;
      pend_valid_d = 1'b0;
    end else begin
      act_d        = act_q;
    end

    if (bus.load) begin
      pend_d       = '{data: bus.data, dp: bus.dp, blank: bus.blank};
      pend_valid_d = 1'b1;
    end else begin
      pend_d       = pend_q;
    end
  end

  // Digit select from the next-state index and active set so seg tracks s
  always_comb begin
    case (s_d)
      2'd0:    nib_s = act_d.data[3:0];
      2'd1:    nib_s = act_d.data[7:4];
      2'd2:    nib_s = act_d.data[11:8];
      2'd3:    nib_s = act_d.data[15:12];
      default: nib_s = act_d.data[3:0];
    endcase
    dp_s    = act_d.dp[s_d];
    blank_s = act_d.blank[s_d];
  end

  hex_to_seg7 u_hex_to_seg7 (
    .nib  (nib_s),
    .seg7 (seg7_s)
  );

  // Segment word for the next cycle, all off when disabled or blanked
  always_comb begin
    if (!bus.en || blank_s) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = {~dp_s, seg7_s};
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      s_q          <= 2'd0;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      act_q        <= '0;
    end else begin
      cnt_q        <= cnt_d;
      s_q          <= s_d;
      seg_q        <= seg_d;
      frame_done_q <= frame_done_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      act_q        <= act_d;
    end
  end

  assign bus.s          = s_q;
  assign bus.seg        = seg_q;
  assign bus.frame_done = frame_done_q;

endmodule
